// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: ALU/load write-back vs. multiply/divide unit, with bounded MDU wait.
// Optional build macro WB_ARB_ZERO_FILTER_EN suppresses rf_we for writes to register 0.
module wb_port_arbiter #(
    parameter int unsigned MAX_WAIT    = 4,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             instruction_20_16,
    input  logic [4:0]             instruction_15_11,
    input  logic                   RegDst,
    input  logic                   alu_we,
    input  logic [31:0]            alu_wdata,
    input  logic                   mdu_valid,
    input  logic [4:0]             mdu_rd,
    input  logic [31:0]            mdu_wdata,
    output logic                   mdu_ready,
    output logic                   stall,
    output logic                   rf_we,
    output logic [4:0]             rf_waddr,
    output logic [31:0]            rf_wdata,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        NORMAL,
        FORCE
    } arb_state_e;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    arb_state_e             arb_state;
    logic [4:0]             alu_rd;
    logic                   grant_alu;
    logic                   grant_mdu;

    logic [7:0]             wait_cnt_q,  wait_cnt_d;
    logic                   rf_we_q,     rf_we_d;
    logic [4:0]             rf_waddr_q,  rf_waddr_d;
    logic [31:0]            rf_wdata_q,  rf_wdata_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        // A non-1 RegDst (including X/Z in simulation) selects rt.
        alu_rd      = (RegDst === 1'b1) ? instruction_15_11 : instruction_20_16;
        arb_state   = NORMAL;
        grant_alu   = 1'b0;
        grant_mdu   = 1'b0;
        stall       = 1'b0;
        wait_cnt_d  = 8'd0;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        stall_cnt_d = stall_cnt_q;

        // FORCE is a pure decode of the wait counter, not a stored state.
        if (mdu_valid && alu_we && (wait_cnt_q == MAX_WAIT_C)) begin
            arb_state = FORCE;
        end

        if (rst_n) begin
            case (arb_state)
                NORMAL: begin
                    if (alu_we) begin
                        grant_alu = 1'b1;
                        if (mdu_valid) begin
                            wait_cnt_d = wait_cnt_q + 8'd1;
                        end
                    end else if (mdu_valid) begin
                        grant_mdu = 1'b1;
                    end
                end
                FORCE: begin
                    grant_mdu = 1'b1;
                    stall     = 1'b1;
                end
                default: ;
            endcase
        end

        if (grant_alu) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = alu_rd;
            rf_wdata_d = alu_wdata;
        end else if (grant_mdu) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = mdu_rd;
            rf_wdata_d = mdu_wdata;
        end

`ifdef WB_ARB_ZERO_FILTER_EN
        // Handshake completes normally; only the enable to the register file is dropped.
        rf_we_d = rf_we_d && (rf_waddr_d != 5'd0);
`else
        rf_we_d = rf_we_d;
`endif

        if (stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign mdu_ready = grant_mdu;

    // NOTE: state flops use non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q  <= 8'd0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= 5'd0;
            rf_wdata_q  <= 32'd0;
            stall_cnt_q <= '0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign stall_cnt = stall_cnt_q;

endmodule
